// File: rtl/shabal_pkg.sv
// Shared definitions for the Shabal front-end: loader FSM states and the
// core word/block geometry.
package shabal_pkg;

  typedef enum logic [2:0] {
    PAD_IDLE,
    PAD_INIT,
    PAD_FILL,
    PAD_SEND,
    PAD_DONE
  } pad_state_t;

  localparam int unsigned SHABAL_IOSIZE      = 16;
  localparam int unsigned SHABAL_BLOCK_WORDS = 32;
  localparam logic [7:0]  SHABAL_PAD_BYTE    = 8'h80;

endpackage

// File: rtl/shabal_pad_loader.sv
// Byte-stream front-end for SHABAL_TOP: packs bytes little-endian into 16-bit
// words, appends 0x80 + zero padding to a 512-bit boundary, and feeds the core.
module shabal_pad_loader
  import shabal_pkg::*;
#(
  parameter int unsigned IOSIZE      = SHABAL_IOSIZE,
  parameter int unsigned BLOCK_WORDS = SHABAL_BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              core_init,
  output logic              core_load,
  output logic [IOSIZE-1:0] core_idata,
  input  logic              core_ack,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WCNT_W = $clog2(BLOCK_WORDS);

  pad_state_t        state;
  logic [IOSIZE-1:0] word;
  logic              half;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_next;
  logic              ended;
  logic              pad_pending;

  assign wcnt_next  = wcnt + 1'b1;
  assign core_idata = word;

  // Outputs are registered alongside the state so each one tracks the state
  // it belongs to, set on the transition into that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PAD_IDLE;
      word        <= '0;
      half        <= 1'b0;
      wcnt        <= '0;
      ended       <= 1'b0;
      pad_pending <= 1'b0;
      in_ready    <= 1'b0;
      core_init   <= 1'b0;
      core_load   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      core_init <= 1'b0;
      done      <= 1'b0;
      case (state)
        PAD_IDLE: begin
          if (in_valid) begin
            state     <= PAD_INIT;
            core_init <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PAD_INIT: begin
          half        <= 1'b0;
          wcnt        <= '0;
          ended       <= 1'b0;
          pad_pending <= 1'b0;
          state       <= PAD_FILL;
          in_ready    <= 1'b1;
        end
        PAD_FILL: begin
          if (in_valid) begin
            if (!half) begin
              if (in_last) begin
                word      <= {SHABAL_PAD_BYTE, in_data};
                ended     <= 1'b1;
                state     <= PAD_SEND;
                in_ready  <= 1'b0;
                core_load <= 1'b1;
              end else begin
                word[7:0] <= in_data;
                half      <= 1'b1;
              end
            end else begin
              word[15:8] <= in_data;
              half       <= 1'b0;
              state      <= PAD_SEND;
              in_ready   <= 1'b0;
              core_load  <= 1'b1;
              if (in_last) begin
                ended       <= 1'b1;
                pad_pending <= 1'b1;
              end
            end
          end
        end
        PAD_SEND: begin
          if (core_ack) begin
            wcnt <= wcnt_next;
            if (!ended) begin
              state     <= PAD_FILL;
              core_load <= 1'b0;
              in_ready  <= 1'b1;
            end else if (pad_pending) begin
              word        <= {8'h00, SHABAL_PAD_BYTE};
              pad_pending <= 1'b0;
            end else if (wcnt_next != '0) begin
              word <= '0;
            end else begin
              state     <= PAD_DONE;
              core_load <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        PAD_DONE: begin
          state <= PAD_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= PAD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shabal_pad_loader.sv
// Self-checking bench for shabal_pad_loader: byte streams with random gaps and
// core back-pressure, checked against a padded-message reference model.
module tb_shabal_pad_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        core_init;
  logic        core_load;
  logic [15:0] core_idata;
  logic        core_ack;
  logic        busy;
  logic        done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Monitor state
  word_q_t     got;
  int unsigned init_cnt, done_cnt, overlap_cnt, unstable_cnt, stall_cycles;
  logic        prev_stalled;
  logic [15:0] prev_word;
  int unsigned ack_delay;
  int unsigned stall_cnt;

  shabal_pad_loader #(.IOSIZE(16), .BLOCK_WORDS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .core_init  (core_init),
    .core_load  (core_load),
    .core_idata (core_idata),
    .core_ack   (core_ack),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Core model: acks each word after ack_delay stalled cycles.
  always @(posedge clk) begin
    #1;
    if (ack_delay == 0) begin
      core_ack = 1'b1;
    end else if (core_load && !core_ack) begin
      if (stall_cnt >= ack_delay) begin
        core_ack  = 1'b1;
        stall_cnt = 0;
      end else begin
        stall_cnt++;
      end
    end else begin
      core_ack  = 1'b0;
      stall_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (core_init) init_cnt++;
    if (done) done_cnt++;
    if (core_load && core_ack) got.push_back(core_idata);
    if (core_load && in_ready) overlap_cnt++;
    if (prev_stalled && core_load && core_idata !== prev_word) unstable_cnt++;
    if (core_load && !core_ack) stall_cycles++;
    prev_stalled = core_load && !core_ack;
    prev_word    = core_idata;
  end

  function automatic word_q_t model_words(input byte_q_t msg);
    byte_q_t p;
    word_q_t w;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 0) p.push_back(8'h00);
    for (int i = 0; i < p.size(); i += 2) w.push_back({p[i+1], p[i]});
    return w;
  endfunction

  task automatic clear_mon();
    got.delete();
    init_cnt = 0; done_cnt = 0; overlap_cnt = 0;
    unstable_cnt = 0; stall_cycles = 0; prev_stalled = 1'b0;
  endtask

  task automatic drive_bytes(input byte_q_t msg, input int unsigned gap_pct);
    logic acc;
    int unsigned n;
    foreach (msg[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(1));
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = (i == msg.size() - 1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end
      n_cmp++;
      if (!acc) begin
        n_err++;
        $display("FAIL byte_accept: byte %0d not accepted (actual in_ready=0, required 1)", i);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (done_cnt == 0 && n < 8000) begin
      @(posedge clk); #2;
      n++;
    end
    n_cmp++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL done_timeout: actual no done, required done within 8000 cycles");
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_stream(input string name, input byte_q_t msg);
    word_q_t exp;
    int unsigned bad;
    int          first_bad;
    exp = model_words(msg);
    n_cmp++;
    if (got.size() !== exp.size()) begin
      n_err++;
      $display("FAIL %s_count: actual %0d words, required %0d", name, got.size(), exp.size());
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s_words: %0d wrong, word %0d actual %h required %h",
               name, bad, first_bad, got[first_bad], exp[first_bad]);
    end
    n_cmp++;
    if (init_cnt !== 1) begin
      n_err++;
      $display("FAIL %s_init: actual %0d core_init pulses, required 1", name, init_cnt);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s_done: actual %0d done pulses, required 1", name, done_cnt);
    end
    n_cmp++;
    if (overlap_cnt !== 0) begin
      n_err++;
      $display("FAIL %s_overlap: actual %0d cycles in_ready with core_load, required 0", name, overlap_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_busy: actual %b, required 0", name, busy);
    end
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input int unsigned gap_pct,
                         input int unsigned delay);
    ack_delay = delay;
    clear_mon();
    drive_bytes(msg, gap_pct);
    wait_done();
    check_stream(name, msg);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; ack_delay = 0;
    core_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({in_ready, core_init, core_load, busy, done} !== 5'b0 || core_idata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: actual rdy=%b init=%b load=%b busy=%b done=%b idata=%h, required all 0",
               in_ready, core_init, core_load, busy, done, core_idata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_one_byte();
    byte_q_t m = '{8'hAB};
    run_msg("one_byte", m, 0, 0);
    n_cmp++;
    if (got.size() == 0 || got[0] !== 16'h80AB) begin
      n_err++;
      $display("FAIL one_byte_first: actual %h, required 80ab", got.size() ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_two_bytes();
    byte_q_t m = '{8'h11, 8'h22};
    run_msg("two_bytes", m, 0, 0);
    n_cmp++;
    if (got.size() < 2 || got[0] !== 16'h2211 || got[1] !== 16'h0080) begin
      n_err++;
      $display("FAIL two_bytes_head: actual size %0d, required 2211 then 0080", got.size());
    end
  endtask

  task automatic test_full_block();
    byte_q_t m;
    for (int i = 0; i < 64; i++) m.push_back(8'(i));
    run_msg("full_block", m, 0, 0);
    n_cmp++;
    if (got.size() != 64 || got[0] !== 16'h0100 || got[31] !== 16'h3F3E || got[32] !== 16'h0080) begin
      n_err++;
      $display("FAIL full_block_marks: actual size %0d, required 64 with 0100/3f3e/0080 at 0/31/32", got.size());
    end
  endtask

  task automatic test_ack_stall();
    byte_q_t m = '{8'h11, 8'h22, 8'h33};
    run_msg("ack_stall", m, 0, 5);
    n_cmp++;
    if (stall_cycles < 5 * 32) begin
      n_err++;
      $display("FAIL ack_stall_cycles: actual %0d stalled cycles, required >= 160", stall_cycles);
    end
    n_cmp++;
    if (unstable_cnt !== 0) begin
      n_err++;
      $display("FAIL ack_stall_stable: actual %0d idata changes while stalled, required 0", unstable_cnt);
    end
    n_cmp++;
    if (got.size() < 2 || got[1] !== 16'h8033) begin
      n_err++;
      $display("FAIL ack_stall_word1: actual size %0d, required second word 8033", got.size());
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t m  = '{8'h11, 8'h22, 8'h33, 8'h44};
    byte_q_t m2 = '{8'h5A};
    ack_delay = 5;
    clear_mon();
    drive_bytes(m, 0);
    @(negedge clk);
    n_cmp++;
    if (!(core_load === 1'b1 && got.size() == 1)) begin
      n_err++;
      $display("FAIL reset_mid_setup: actual load=%b words=%0d, required load=1 words=1", core_load, got.size());
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, core_init, core_load, busy, done} !== 5'b0 || core_idata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: actual rdy=%b init=%b load=%b busy=%b done=%b idata=%h, required all 0",
               in_ready, core_init, core_load, busy, done, core_idata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_msg("after_reset", m2, 0, 0);
    n_cmp++;
    if (got.size() == 0 || got[0] !== 16'h805A) begin
      n_err++;
      $display("FAIL after_reset_first: actual %h, required 805a", got.size() ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_gaps();
    byte_q_t m;
    word_q_t ref_run;
    for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
    run_msg("gapfree10", m, 0, 0);
    ref_run = got;
    run_msg("gappy10", m, 50, 0);
    n_cmp++;
    if (got != ref_run) begin
      n_err++;
      $display("FAIL gap_equiv: actual %0d words differ from gap-free run of %0d", got.size(), ref_run.size());
    end
  endtask

  task automatic test_random();
    for (int unsigned r = 0; r < 6; r++) begin
      byte_q_t m;
      int unsigned len = $urandom_range(140, 1);
      for (int unsigned i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", r), m, $urandom_range(40), $urandom_range(3));
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t a = '{8'h01, 8'h02, 8'h03};
    byte_q_t b;
    for (int i = 0; i < 63; i++) b.push_back(8'($urandom));
    run_msg("b2b_a", a, 0, 0);
    run_msg("b2b_b", b, 0, 1);
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_bytes();
    test_full_block();
    test_ack_stall();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shabal_pad_loader.md
# shabal_pad_loader

Upstream feeder for `SHABAL_TOP`. It accepts a message as a byte stream and packs bytes little-endian into 16-bit words. It applies Shabal padding (a single 0x80 byte, then zeros up to a 512-bit block boundary) and drives the core's `init`/`load`/`idata`/`ack` word handshake. It sits between the message source and the hash core; the digest is read from the core separately via `fetch`.

## Interface
- `IOSIZE`, 16, core word width (fixed; the block handles exactly 2 bytes per word).
- `BLOCK_WORDS`, 32, words per 512-bit block.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: source has a message byte on `in_data`.
- `in_data` input 8: message byte.
- `in_last` input 1: qualifies the final byte of the message (messages are ≥1 byte).
- `in_ready` output 1: byte accepted on a cycle with `in_valid & in_ready`.
- `core_init` output 1: one-cycle pulse to the core at message start.
- `core_load` output 1: word request to the core.
- `core_idata` output 16: word to the core; bits [7:0] are the earlier byte.
- `core_ack` input 1: core accepted the word; a transfer occurs on a cycle with `core_load & core_ack`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the last padded word has transferred.

## Operation
- States: IDLE, INIT, FILL, SEND, DONE.
- **IDLE**: `in_ready=0`. Moves to INIT when `in_valid=1`; that byte is not consumed in IDLE.
- **INIT**: `core_init=1` for exactly 1 cycle. Clears the half flag, word counter `wcnt` (5 bits), `ended` and `pad_pending`. Moves to FILL.
- **FILL**: `in_ready=1`.
  - Half 0: byte goes to `word[7:0]`, half←1.
  - Half 1: byte goes to `word[15:8]`, half←0, then SEND.
  - `in_last` at half 0: `word={8'h80, byte}`, ended←1, then SEND.
  - `in_last` at half 1: `word[15:8]=byte`, ended←1, pad_pending←1, then SEND.
- **SEND**: `core_load=1`, `core_idata=word`, both held stable until `core_ack`. On ack, `wcnt` increments modulo 32. Next state, in priority order:
  - `!ended` → FILL.
  - `pad_pending` → `word=16'h0080`, pad_pending←0, stay in SEND.
  - `wcnt_next!=0` → `word=16'h0000`, stay in SEND.
  - Otherwise → DONE.
- **DONE**: `done=1` for 1 cycle, then IDLE.
- A message that ends exactly on a block boundary always gets a full extra pad block. Padding therefore always contributes at least the 0x80 byte.
- Total words sent per message = 32·(floor(L/64)+1), where L is the byte length.
- `in_valid` gaps in FILL stall without side effects. `in_ready` stays 0 in SEND, so the source is never accepted while a word is pending.

## Timing
- Reset value of all outputs is 0 and the state is IDLE. A reset mid-message discards the partial word and all counters. The next message starts with a fresh `core_init`.
- First `in_valid` in IDLE → `core_init` high on the next cycle → `in_ready` high on the cycle after that.
- Word latency: `core_load` rises on the cycle after the second byte of a word is accepted.
- Same-cycle `core_ack` is allowed, which gives a minimum of 3 cycles per data word (2 FILL + 1 SEND).
- Pad words can stream back-to-back, one per cycle, when `core_ack` is held high.
- `done` asserts on the cycle after the final acked word.
- `in_last` with `in_valid=0` is ignored.

## Structure
- Shared package `shabal_pkg` holds:
  - the state enum `pad_state_t`;
  - `SHABAL_IOSIZE=16`;
  - `SHABAL_BLOCK_WORDS=32`;
  - `SHABAL_PAD_BYTE=8'h80`.
- Single flat module with no sub-module. The FSM, the 16-bit word register, the half flag, `wcnt`, `ended` and `pad_pending` all live in one file.

## Test plan
- One-byte message 0xAB, ack always high → `core_init` pulse, then 0x80AB, then 31×0x0000, then `done`; 32 transfers total.
- Two bytes 0x11, 0x22 → 0x2211, 0x0080, then 30×0x0000, then `done`.
- 64 bytes 0x00..0x3F → 32 data words (first 0x0100, last 0x3F3E), then 0x0080 plus 31×0x0000; 64 transfers.
- 3 bytes with `core_ack` delayed 5 cycles per word → `core_load`/`core_idata` constant during the stall and `in_ready=0` throughout; words 0x2211-style packing, then 0x8033 (third byte 0x33 in the low half), then 30 zeros.
- Reset asserted during SEND of the second word → all outputs 0 immediately. A following 1-byte message 0x5A produces a new `core_init` and 0x805A first.
- Random `in_valid` gaps on a 10-byte message → word stream identical to the gap-free run.
